// File: rtl/mips_mon_pkg.sv
// Shared types and defaults for the run-completion monitor and the pipeline top.
package mips_mon_pkg;

    // Monitor FSM states; encoding is visible on the state output.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        TMO   = 2'd3
    } mon_state_e;

    localparam int DEF_PC_W       = 32;
    localparam int DEF_PIPE_DEPTH = 5;
    localparam int DEF_CNT_W      = 32;

endpackage

// File: rtl/run_completion_monitor_if.sv
// Pipeline-to-monitor signal bundle: fetch/hazard/retire observations in,
// completion status and counters out.
interface run_completion_monitor_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             if_valid_x70;
    logic [PC_W-1:0]  if_pc_x70;
    logic             stall_x70;
    logic             flush_x70;
    logic             wb_retire_x70;
    logic             finished_x70;
    logic             timeout_x70;
    logic [1:0]       state_x70;
    logic [CNT_W-1:0] cycle_count_x70;
    logic [CNT_W-1:0] retire_count_x70;

    // Core / bench side: drives pipeline events, observes status.
    modport master (
        output if_valid_x70, if_pc_x70, stall_x70, flush_x70, wb_retire_x70,
        input  finished_x70, timeout_x70, state_x70, cycle_count_x70, retire_count_x70
    );

    // Monitor side.
    modport slave (
        input  if_valid_x70, if_pc_x70, stall_x70, flush_x70, wb_retire_x70,
        output finished_x70, timeout_x70, state_x70, cycle_count_x70, retire_count_x70
    );
endinterface

// File: rtl/run_completion_monitor_sat_counter.sv
// Saturating up-counter: counts enabled cycles, sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Increment when enabled unless already at the top value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/run_completion_monitor.sv
// Completion monitor for the 5-stage core: raises finished once the last
// program instruction has drained through WB, or timeout if the cycle
// budget runs out first.
module run_completion_monitor
    import mips_mon_pkg::*;
#(
    parameter int              PC_W       = DEF_PC_W,
    parameter logic [PC_W-1:0] END_PC     = PC_W'('h3C),
    parameter int              PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int              CNT_W      = DEF_CNT_W,
    parameter int              MAX_CYCLES = 100000
) (
    input logic                     clk_x70,
    input logic                     rst_n_x70,
    run_completion_monitor_if.slave bus
);

    localparam int              DW         = $clog2(PIPE_DEPTH);
    localparam logic [DW-1:0]   DRAIN_LOAD = DW'(PIPE_DEPTH - 1);
    localparam logic [CNT_W-1:0] TMO_AT    = CNT_W'(MAX_CYCLES - 1);

    if (PIPE_DEPTH < 2) begin : g_bad_depth
        $error("run_completion_monitor: PIPE_DEPTH must be >= 2");
    end

    mon_state_e    state, state_nx;
    logic [DW-1:0] drain_cnt, drain_nx;
    logic          finished_q, timeout_q;
    logic          end_fetch, tmo_hit, counting;
    logic [CNT_W-1:0] cycle_cnt;

    assign end_fetch = bus.if_valid_x70 && !bus.stall_x70 && !bus.flush_x70 &&
                       (bus.if_pc_x70 == END_PC);
    assign counting  = (state == RUN) || (state == DRAIN);
    assign tmo_hit   = counting && (cycle_cnt == TMO_AT);

    // Next state and drain countdown; timeout outranks every other move.
    always_comb begin
        state_nx = state;
        drain_nx = drain_cnt;
        unique case (state)
            RUN: begin
                if (tmo_hit) begin
                    state_nx = TMO;
                end else if (end_fetch) begin
                    state_nx = DRAIN;
                    drain_nx = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (tmo_hit) begin
                    state_nx = TMO;
                end else if (bus.flush_x70) begin
                    // The end fetch was wrong-path; wait for the real one.
                    state_nx = RUN;
                    drain_nx = '0;
                end else if (!bus.stall_x70) begin
                    if (drain_cnt == DW'(1)) begin
                        state_nx = DONE;
                        drain_nx = '0;
                    end else begin
                        drain_nx = drain_cnt - DW'(1);
                    end
                end
            end
            default: ;  // DONE and TMO hold until reset
        endcase
    end

    // State, countdown and sticky flags; flags track entry into the final states.
    always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
        if (!rst_n_x70) begin
            state      <= RUN;
            drain_cnt  <= '0;
            finished_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            drain_cnt  <= drain_nx;
            finished_q <= (state_nx == DONE);
            timeout_q  <= (state_nx == TMO);
        end
    end

    // Cycles spent monitoring; freezes once DONE or TMO is reached.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk_x70),
        .rst_n (rst_n_x70),
        .en    (counting),
        .cnt   (cycle_cnt)
    );

    // Retired instructions while monitoring.
    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk_x70),
        .rst_n (rst_n_x70),
        .en    (counting && bus.wb_retire_x70),
        .cnt   (bus.retire_count_x70)
    );

    assign bus.cycle_count_x70 = cycle_cnt;
    assign bus.finished_x70    = finished_q;
    assign bus.timeout_x70     = timeout_q;
    assign bus.state_x70       = state;

endmodule

// File: tb/tb_run_completion_monitor.sv
// Bench for run_completion_monitor: constant vector table, directed
// multi-cycle scenarios and randomized runs against a pipeline-position model.
module tb_run_completion_monitor;
    import mips_mon_pkg::*;

    localparam int          PC_W   = 32;
    localparam int          CNT_W  = 32;
    localparam int          PD     = 5;
    localparam int          MAXC   = 50;
    localparam logic [31:0] END_PC = 32'h3C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    run_completion_monitor_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    run_completion_monitor #(
        .PC_W(PC_W), .END_PC(END_PC), .PIPE_DEPTH(PD), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)
    ) dut (
        .clk_x70   (clk),
        .rst_n_x70 (rst_n),
        .bus       (bus)
    );

    logic       sc_en = 1'b0;
    logic [2:0] sc_cnt;
    sat_counter #(.W(3)) u_sc (.clk(clk), .rst_n(rst_n), .en(sc_en), .cnt(sc_cnt));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: phase 0 idle, 1 end instruction in flight, 2 finished, 3 timed out.
    int     m_phase;
    int     m_pos;   // pipeline stage holding the end instruction (1=ID .. PD-1=WB)
    longint m_cyc, m_ret;

    // Event cycles for the straight-line program.
    int k_end, k_stall_at, k_stall_len, k_flush_at, k_refetch;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        st, fl, rt;
        logic [1:0]  e_state;
        logic        e_fin;
        logic [31:0] e_cyc, e_ret;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] act_out();
        return 72'({bus.state_x70, bus.finished_x70, bus.timeout_x70,
                    bus.cycle_count_x70, bus.retire_count_x70});
    endfunction

    function automatic logic [71:0] exp_out();
        logic [1:0] ph;
        ph = m_phase[1:0];
        return 72'({ph, (m_phase == 2), (m_phase == 3), m_cyc[31:0], m_ret[31:0]});
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_cyc = 0; m_ret = 0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] pc,
                              input logic st, input logic fl, input logic rt);
        logic act;
        act = (m_phase < 2);
        if (act && m_cyc == longint'(MAXC - 1)) begin
            m_phase = 3;
        end else if (m_phase == 1) begin
            if (fl) m_phase = 0;
            else if (!st) begin
                if (m_pos == PD - 1) m_phase = 2;
                else m_pos++;
            end
        end else if (m_phase == 0 && v && !st && !fl && pc == END_PC) begin
            m_phase = 1;
            m_pos   = 1;
        end
        if (act) begin
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
            if (rt && m_ret < 64'hFFFF_FFFF) m_ret++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.if_valid_x70 = 1'b0; bus.if_pc_x70 = '0; bus.stall_x70 = 1'b0;
        bus.flush_x70 = 1'b0; bus.wb_retire_x70 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        chk("reset", act_out(), 72'd0);
    endtask

    // One clock: drive inputs, advance model, compare all outputs after the edge.
    task automatic step(input logic v, input logic [31:0] pc,
                        input logic st, input logic fl, input logic rt);
        bus.if_valid_x70 = v; bus.if_pc_x70 = pc; bus.stall_x70 = st;
        bus.flush_x70 = fl; bus.wb_retire_x70 = rt;
        model_edge(v, pc, st, fl, rt);
        @(posedge clk);
        #1;
        cyc++;
        chk($sformatf("cycle%0d", cyc), act_out(), exp_out());
    endtask

    // Straight-line program: loop body PCs 0..0x38, END_PC at the chosen cycles.
    task automatic run_to(input int target);
        int k;
        logic [31:0] pc;
        while (cyc < target) begin
            k  = cyc;
            pc = 32'(4 * (k % 15));
            if (k == k_end || k == k_refetch) pc = END_PC;
            step(1'b1, pc, (k >= k_stall_at && k < k_stall_at + k_stall_len),
                 (k == k_flush_at), (k >= 4 && k < 25));
        end
    endtask

    task automatic scen(input int e, input int sa, input int sl, input int fa, input int rf);
        k_end = e; k_stall_at = sa; k_stall_len = sl; k_flush_at = fa; k_refetch = rf;
    endtask

    initial begin
        bus.if_valid_x70 = 1'b0; bus.if_pc_x70 = '0; bus.stall_x70 = 1'b0;
        bus.flush_x70 = 1'b0; bus.wb_retire_x70 = 1'b0;

        // Blocked end fetches, then a clean one with a stall inside DRAIN.
        //          v     pc      st    fl    rt    state fin  cyc    ret
        tbl[0]  = '{1'b1, END_PC, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'd1,  32'd0};
        tbl[1]  = '{1'b1, END_PC, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd2,  32'd0};
        tbl[2]  = '{1'b0, END_PC, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd3,  32'd0};
        tbl[3]  = '{1'b1, 32'h38, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'd4,  32'd1};
        tbl[4]  = '{1'b1, END_PC, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'd5,  32'd1};
        tbl[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'd6,  32'd2};
        tbl[6]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'd7,  32'd2};
        tbl[7]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'd8,  32'd2};
        tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'd9,  32'd2};
        tbl[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 32'd10, 32'd2};
        tbl[10] = '{1'b1, END_PC, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 32'd10, 32'd2};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].pc, tbl[i].st, tbl[i].fl, tbl[i].rt);
            chk($sformatf("tbl%0d", i), act_out(),
                72'({tbl[i].e_state, tbl[i].e_fin, 1'b0, tbl[i].e_cyc, tbl[i].e_ret}));
        end

        // Straight-line run: end fetch at 20, finished at 25.
        scen(20, -1, 0, -1, -1);
        do_reset();
        run_to(21); chk("s1_drain", 72'(bus.state_x70), 72'd1);
        run_to(24); chk("s1_fin_early", 72'(bus.finished_x70), 72'd0);
        run_to(25); chk("s1_fin", 72'(bus.finished_x70), 72'd1);
        chk("s1_cycles", 72'(bus.cycle_count_x70), 72'd25);
        chk("s1_retired", 72'(bus.retire_count_x70), 72'd21);
        run_to(28); chk("s1_frozen", 72'(bus.cycle_count_x70), 72'd25);

        // Two stall cycles in DRAIN push completion to 27.
        scen(20, 22, 2, -1, -1);
        do_reset();
        run_to(26); chk("s2_fin_early", 72'(bus.finished_x70), 72'd0);
        run_to(27); chk("s2_fin", 72'(bus.finished_x70), 72'd1);
        chk("s2_cycles", 72'(bus.cycle_count_x70), 72'd27);

        // Wrong-path end fetch flushed at DRAIN+1, real one at 30.
        scen(20, -1, 0, 22, 30);
        do_reset();
        run_to(23); chk("s3_back_run", 72'(bus.state_x70), 72'd0);
        run_to(34); chk("s3_fin_early", 72'(bus.finished_x70), 72'd0);
        run_to(35); chk("s3_fin", 72'(bus.finished_x70), 72'd1);

        // END_PC never fetched: timeout at 50.
        scen(-1, -1, 0, -1, -1);
        do_reset();
        run_to(49); chk("s5_no_tmo", 72'(bus.timeout_x70), 72'd0);
        run_to(50); chk("s5_tmo", 72'({bus.state_x70, bus.timeout_x70}), 72'({2'd3, 1'b1}));
        chk("s5_cycles", 72'(bus.cycle_count_x70), 72'd50);
        run_to(56); chk("s5_hold", 72'({bus.finished_x70, bus.timeout_x70, bus.cycle_count_x70}),
                        72'({1'b0, 1'b1, 32'd50}));

        // Asynchronous reset mid-DRAIN, then a clean rerun.
        scen(20, -1, 0, -1, -1);
        do_reset();
        run_to(23);
        #2 rst_n = 1'b0;
        #1 chk("s6_async_clear", act_out(), 72'd0);
        do_reset();
        run_to(25);
        chk("s6_rerun", 72'({bus.finished_x70, bus.cycle_count_x70, bus.retire_count_x70}),
            72'({1'b1, 32'd25, 32'd21}));

        // Saturation of the counter building block.
        do_reset();
        sc_en = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("sat_6", 72'(sc_cnt), 72'd6);
        repeat (4) @(posedge clk);
        #1 chk("sat_hold", 72'(sc_cnt), 72'd7);
        sc_en = 1'b0;

        // Randomized pipeline traffic against the model.
        for (int r = 0; r < 25; r++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                logic [31:0] pc;
                pc = ($urandom_range(0, 7) == 0) ? END_PC : 32'({$urandom_range(0, 15), 2'b00});
                step(($urandom_range(0, 3) != 0), pc, ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
